fpmult_normalize_stage: RTL and testbench
=========================================

FPMULT_NORMALIZE_STAGE -- requirements
Module: fpmult_normalize_stage

Interface
REQ-001 Parameter PROD_W, default 48, width of the raw 24x24 mantissa product.
REQ-002 Parameter MANT_W, default 23, width of the normalized mantissa field.
REQ-003 Parameter EXP_W, default 9, width of the exponent (bit 8 carries the overflow/underflow indication to the rounding stage).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream product and exponent are valid this cycle.
REQ-007 in_ready  output  1  stage accepts a transfer this cycle.
REQ-008 Sign  input  1  product sign (Sa xor Sb).
REQ-009 Mprod  input  PROD_W  unsigned mantissa product with hidden bits, range [1.0, 4.0).
REQ-010 Eprod  input  EXP_W  biased exponent sum (Ea+Eb-127), computed upstream.
REQ-011 out_valid  output  1  normalized result is valid.
REQ-012 out_ready  input  1  rounding stage accepts the result.
REQ-013 NormS  output  1  sign, passed through.
REQ-014 NormM  output  MANT_W  normalized mantissa without hidden bit.
REQ-015 NormE  output  EXP_W  adjusted exponent.
REQ-016 G, R, S  output  1 each  guard, round and sticky bits.
REQ-017 Zero  output  1  Mprod was all zeros.

Function
REQ-018 A transfer occurs on a cycle with in_valid and in_ready both high; an output transfer on a cycle with out_valid and out_ready both high.
REQ-019 Two register stages: S1 captures Sign/Mprod/Eprod; S2 holds the normalized result; latency from input transfer to out_valid is exactly 2 cycles when unstalled.
REQ-020 S2 loads when S2 is empty or out_ready is high; S1 loads when S1 is empty or S1 is moving into S2; in_ready = !s1_valid || s2_load.
REQ-021 Throughput: one result per cycle while out_ready stays high; no bubbles are inserted.
REQ-022 Stall: with out_ready low, S2 and S1 hold their contents unchanged, at most 2 items are buffered, and in_ready drops once both are full.
REQ-023 in_ready is a registered-state function only; it has no combinational path from in_valid.
REQ-024 Mprod[47]=1: NormM=Mprod[46:24], G=Mprod[23], R=Mprod[22], S=OR(Mprod[21:0]), NormE=Eprod+1.
REQ-025 Mprod[47]=0: NormM=Mprod[45:23], G=Mprod[22], R=Mprod[21], S=OR(Mprod[20:0]), NormE=Eprod.
REQ-026 NormE addition is modular in EXP_W bits; no saturation (overflow handling belongs to the rounding stage).
REQ-027 Mprod==0: Zero=1, NormM=0, NormE=0, G=R=S=0; NormS still passes through.
REQ-028 Output data registers are updated only when S2 loads; they are stable while out_valid is high and out_ready is low.
REQ-029 Input data presented while in_ready is low is ignored.

Reset
REQ-030 While rst is high at a clock edge, s1_valid, out_valid and all data registers clear to 0; in_ready reads 1 on the cycle after reset.
REQ-031 Reset mid-operation discards buffered items; no output transfer occurs for items accepted before reset.

Structure
REQ-032 Shared package fpmult_pkg holds PROD_W, MANT_W, EXP_W and the bias constant 127.
REQ-033 One sub-module, fpmult_pipe_reg (valid/ready register slice with data width parameter), instantiated for S1 and S2; normalization logic sits between them.

Verification
REQ-034 Mprod=48'h8000_0000_0000, Eprod=9'h080, out_ready=1 -> 2 cycles later NormM=0, NormE=9'h081, G=R=S=0, Zero=0.
REQ-035 Mprod=48'h4000_00C0_0001, Eprod=9'h080 -> NormM=23'h000001, NormE=9'h080, G=1, R=0, S=1.
REQ-036 Mprod=48'hC000_0000_0000, Eprod=9'h1FF -> NormE=9'h000 (wrap), NormM=23'h400000, G=R=S=0.
REQ-037 out_ready=0, in_valid=1 for 4 cycles with tags A,B,C,D -> A,B accepted, in_ready low after cycle 2; on out_ready=1, outputs A,B,C,D emerge in order with no loss or duplication.
REQ-038 Mprod=0, Sign=1 -> Zero=1, NormS=1, NormM=0, NormE=0.
REQ-039 rst asserted with 2 items buffered -> next cycle out_valid=0, in_ready=1; the buffered items never appear at the output.

Source files
------------

// File: rtl/fpmult_pkg.sv
// fpmult_pkg: shared widths and exponent bias for the FP multiplier pipeline
package fpmult_pkg;
  localparam int FP_PROD_W = 48;
  localparam int FP_MANT_W = 23;
  localparam int FP_EXP_W  = 9;
  localparam int FP_BIAS   = 127;
endpackage

// File: rtl/fpmult_pipe_reg.sv
// fpmult_pipe_reg: one-entry valid/ready register slice
module fpmult_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  always_comb begin
    valid_d = in_ready ? in_valid : valid_q;
    data_d  = in_ready ? in_data : data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/fpmult_normalize_stage.sv
// fpmult_normalize_stage: two-slice pipeline normalizing a [1,4) mantissa product
module fpmult_normalize_stage
  import fpmult_pkg::*;
#(
  parameter int PROD_W = FP_PROD_W,
  parameter int MANT_W = FP_MANT_W,
  parameter int EXP_W  = FP_EXP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              Sign,
  input  logic [PROD_W-1:0] Mprod,
  input  logic [EXP_W-1:0]  Eprod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              NormS,
  output logic [MANT_W-1:0] NormM,
  output logic [EXP_W-1:0]  NormE,
  output logic              G,
  output logic              R,
  output logic              S,
  output logic              Zero
);
  localparam int S1_W = 1 + PROD_W + EXP_W;
  localparam int S2_W = MANT_W + EXP_W + 5;
  logic              s1_valid, s2_ready;
  logic [S1_W-1:0]   s1_data;
  logic [S2_W-1:0]   norm_data, s2_data;
  logic              s1_sign, hi, zero, g, r, st;
  logic [PROD_W-1:0] s1_m;
  logic [EXP_W-1:0]  s1_e, e;
  logic [MANT_W-1:0] mant;
  assign {s1_sign, s1_m, s1_e} = s1_data;
  assign {NormS, NormM, NormE, G, R, S, Zero} = s2_data;
  fpmult_pipe_reg #(.W(S1_W)) u_s1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data({Sign, Mprod, Eprod}),
    .out_valid(s1_valid), .out_ready(s2_ready), .out_data(s1_data)
  );
  // A product >= 2.0 shifts one extra place right and bumps the exponent
  always_comb begin
    hi        = s1_m[PROD_W-1];
    zero      = s1_m == '0;
    mant      = hi ? s1_m[PROD_W-2 -: MANT_W] : s1_m[PROD_W-3 -: MANT_W];
    g         = hi ? s1_m[PROD_W-2-MANT_W] : s1_m[PROD_W-3-MANT_W];
    r         = hi ? s1_m[PROD_W-3-MANT_W] : s1_m[PROD_W-4-MANT_W];
    st        = hi ? |s1_m[PROD_W-4-MANT_W:0] : |s1_m[PROD_W-5-MANT_W:0];
    e         = s1_e + EXP_W'(hi);
    norm_data = zero ? {s1_sign, {(S2_W-2){1'b0}}, 1'b1} : {s1_sign, mant, e, g, r, st, 1'b0};
  end
  fpmult_pipe_reg #(.W(S2_W)) u_s2 (
    .clk(clk), .rst(rst),
    .in_valid(s1_valid), .in_ready(s2_ready), .in_data(norm_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(s2_data)
  );
endmodule

// File: tb/tb_fpmult_normalize_stage.sv
// tb_fpmult_normalize_stage: directed vectors checked against an arithmetic reference model
module tb_fpmult_normalize_stage;
  typedef struct packed {
    logic        s;
    logic [22:0] m;
    logic [8:0]  e;
    logic        g, r, st, z;
  } res_t;
  logic        clk = 0, rst, in_valid, in_ready, Sign, out_valid, out_ready;
  logic        NormS, G, R, S, Zero;
  logic [47:0] Mprod;
  logic [8:0]  Eprod, NormE;
  logic [22:0] NormM;
  res_t        act;
  res_t        q[$];
  logic [8:0]  seen[$];
  int          errors = 0, checks = 0, cyc = 0;
  assign act = {NormS, NormM, NormE, G, R, S, Zero};
  fpmult_normalize_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Sign(Sign), .Mprod(Mprod), .Eprod(Eprod),
    .out_valid(out_valid), .out_ready(out_ready),
    .NormS(NormS), .NormM(NormM), .NormE(NormE), .G(G), .R(R), .S(S), .Zero(Zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string name, logic [63:0] a, logic [63:0] b);
    checks++;
    if (a !== b) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, a, b);
    end
  endtask
  // Value = Mprod / 2^46 in [1,4); the mantissa keeps 23 bits below the leading one.
  function automatic res_t model(logic s, logic [47:0] m, logic [8:0] e);
    res_t o;
    longint unsigned mv = 64'(m);
    int sh;
    o = '0;
    o.s = s;
    if (mv == 0) begin
      o.z = 1'b1;
      return o;
    end
    sh = (mv >= 64'h8000_0000_0000) ? 24 : 23;
    o.m = 23'((mv >> sh) % (64'd1 << 23));
    o.g = 1'((mv >> (sh - 1)) % 2);
    o.r = 1'((mv >> (sh - 2)) % 2);
    o.st = (mv % (64'd1 << (sh - 2))) != 0;
    o.e = 9'((int'(e) + (sh == 24 ? 1 : 0)) % 512);
    return o;
  endfunction
  task automatic send(logic s, logic [47:0] m, logic [8:0] e);
    bit ok = 0;
    Sign = s; Mprod = m; Eprod = e; in_valid = 1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      check("send_timeout", 0, 1);
      in_valid = 0;
      return;
    end
    @(posedge clk); #1;
  endtask
  task automatic lit(string name, logic s, logic [47:0] m, logic [8:0] e, res_t x);
    out_ready = 1; Sign = s; Mprod = m; Eprod = e; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    @(posedge clk);
    @(negedge clk);
    check({name, "_valid"}, out_valid, 1);
    check(name, act, x);
    @(posedge clk); #1;
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    check("drain", q.size(), 0);
    @(posedge clk); #1;
  endtask
  logic [47:0] vm[8] = '{48'h8000_0000_0000, 48'h4000_0000_0000, 48'hFFFF_FFFF_FFFF, 48'h4000_0040_0000,
                         48'h8000_0080_0000, 48'h0, 48'h5A5A_A5A5_3C3C, 48'hC000_0000_0001};
  logic [8:0]  ve[8] = '{9'h07F, 9'h1FF, 9'h100, 9'h001, 9'h0FE, 9'h033, 9'h1FE, 9'h000};
  initial begin
    int c0;
    rst = 1; in_valid = 0; out_ready = 1; Sign = 0; Mprod = 0; Eprod = 0;
    fork
      forever begin
        @(negedge clk);
        if (rst) q.delete();
        else begin
          check("in_ready", in_ready, q.size() < 2 || out_ready);
          if (out_valid) check("out_valid_without_item", q.size() > 0, 1);
          if (out_valid && !out_ready && q.size() > 0) check("stall_hold", act, q[0]);
          if (out_valid && out_ready && q.size() > 0) begin
            check("result", act, q.pop_front());
            seen.push_back(NormE);
          end
          if (in_valid && in_ready) q.push_back(model(Sign, Mprod, Eprod));
        end
      end
    join_none
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_data", act, 0);
    @(posedge clk); #1;
    lit("req034", 0, 48'h8000_0000_0000, 9'h080, '{1'b0, 23'h0, 9'h081, 1'b0, 1'b0, 1'b0, 1'b0});
    lit("req035", 0, 48'h4000_00C0_0001, 9'h080, '{1'b0, 23'h000001, 9'h080, 1'b1, 1'b0, 1'b1, 1'b0});
    lit("req036", 0, 48'hC000_0000_0000, 9'h1FF, '{1'b0, 23'h400000, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0});
    lit("req038", 1, 48'h0, 9'h0AB, '{1'b1, 23'h0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1});
    lit("all_ones", 0, 48'h7FFF_FFFF_FFFF, 9'h07F, '{1'b0, 23'h7FFFFF, 9'h07F, 1'b1, 1'b1, 1'b1, 1'b0});
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(i[0], vm[i], ve[i]);
    check("burst_cycles", cyc - c0, 8);
    in_valid = 0;
    drain();
    out_ready = 0;
    seen.delete();
    send(0, 48'h4000_0000_0000, 9'h0A1);
    send(0, 48'h4000_0000_0000, 9'h0B2);
    Sign = 0; Mprod = 48'h4000_0000_0000; Eprod = 9'h0C3; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1;
    send(0, 48'h4000_0000_0000, 9'h0C3);
    send(0, 48'h4000_0000_0000, 9'h0D4);
    in_valid = 0;
    drain();
    check("order_count", seen.size(), 4);
    if (seen.size() == 4) begin
      check("order_a", seen[0], 9'h0A1);
      check("order_b", seen[1], 9'h0B2);
      check("order_c", seen[2], 9'h0C3);
      check("order_d", seen[3], 9'h0D4);
    end
    fork
      for (int i = 0; i < 8; i++) send(~i[0], vm[7 - i], ve[i]);
      repeat (30) begin
        @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
      end
    join
    in_valid = 0; out_ready = 1;
    drain();
    out_ready = 0;
    send(0, 48'h8000_0000_0000, 9'h011);
    send(1, 48'h4000_0000_0000, 9'h022);
    in_valid = 0; rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    @(posedge clk); #1 out_ready = 1;
    repeat (4) begin
      @(negedge clk);
      check("rst_no_output", out_valid, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
